ltc2308_emulator: RTL
=====================

Name: ltc2308_emulator

Overview:
- Synthesizable responder model of the LTC2308 8-channel 12-bit SPI ADC.
- Drives the ADC side of the CONVST/SCK/SDI/SDO interface so our ADC master controller and FIFO path can be exercised in loopback, on the board or in simulation, without the real chip.
- Per-channel sample values come from a parallel input bus, e.g. an NCO or counter bank.
- Oversamples all interface pins on its own clock.

Parameters:
- DATA_BITS, 12, conversion result width.
- CMD_BITS, 6, config word width: S/D, O/S, S1, S0, UNI, SLP.
- T_CONV_CYC, 260, emulated conversion time in clk cycles (1.3 us at 200 MHz).
- CFG_DEFAULT, 6'b100010, power-on config: CH0, unipolar, no sleep.

Ports:
- clk  in  1  emulator clock; SCK high and low times must each be ≥4 clk periods.
- reset_n  in  1  asynchronous, active-low reset.
- ch_data  in  96  eight 12-bit unipolar samples; CHn at [12n+11:12n].
- ADC_CONVST  in  1  conversion start from master.
- ADC_SCK  in  1  serial clock from master.
- ADC_SDI  in  1  config bits from master.
- ADC_SDO  out  1  result bits to master.
- conv_start  out  1  one-clk pulse when a conversion is latched.
- conv_ch  out  3  channel of the current conversion.
- cfg_word  out  6  config in force for the next conversion.
- frame_done  out  1  one-clk pulse after the 12th SCK rising edge.
- proto_err  out  1  one-clk pulse on any protocol violation.
- diff_seen  out  1  sticky flag; set when a differential config (S/D=0) is accepted.

Behaviour:
- Reset (async, mid-operation included):
  - state=IDLE, ADC_SDO=0, cfg_word=CFG_DEFAULT, conv_ch=0, diff_seen=0, all pulses 0.
  - Synchronizers, counters and shift registers are cleared.
- Input sampling:
  - CONVST, SCK and SDI pass through 2-FF synchronizers.
  - Edges are detected from the sync output against its 1-clk delayed copy.
  - All decisions below use these detected edges.
- IDLE:
  - SDO=0.
  - CONVST rising edge -> CONV: load conversion counter with T_CONV_CYC-1.
  - Same cycle: latch sample = ch_data for channel {S1,S0,O/S} = {cfg[3],cfg[2],cfg[4]}; drive conv_ch; pulse conv_start.
  - Mapping: 100010->CH0, 110010->CH1, 100110->CH2, 111110->CH7.
- Data coding at latch:
  - UNI=1: code = sample.
  - UNI=0: code = sample XOR 12'h800 (offset binary to two's complement).
  - S/D=0: code = 0 and diff_seen is set.
- CONV:
  - Counter decrements each clk.
  - Any SCK edge in CONV -> proto_err pulse; the edge is otherwise ignored.
  - Counter==0 -> SHIFT; same cycle load out_sr=code and bit_cnt=0; SDO=code[11].
- SHIFT:
  - SCK rising edge: if bit_cnt<CMD_BITS, shift SDI into cfg_sr MSB-first; then bit_cnt+1.
  - SCK falling edge: shift out_sr left; SDO = next bit. After the 12th falling edge SDO=0.
  - 12th rising edge -> frame_done pulse; go to DONE.
  - The new cfg_word is committed from cfg_sr on the 12th rising edge (frame_done cycle), as soon as bit_cnt has reached CMD_BITS. It applies to the next conversion (one-frame pipeline, as on the real part).
- DONE:
  - SDO=0 once the trailing falling edge arrives; extra SCK edges -> proto_err pulse.
  - CONVST rising edge -> behaves as in IDLE.
- CONVST rising edge during SHIFT with bit_cnt<12:
  - proto_err pulse; frame aborted.
  - If bit_cnt≥6, cfg_sr is still committed to cfg_word; otherwise cfg_word is unchanged.
  - A new conversion then starts exactly as from IDLE.
- CONVST rising edge during CONV: proto_err pulse; ignored, conversion continues.
- SLP bit: stored in cfg_word only; no sleep behaviour is modelled.
- SDO change latency: 3 clk after the SCK falling edge at the pin (2 sync + 1 register). This is within half an SCK period by the clk constraint.

Test Plan:
- Reset, ch_data CH0=12'hABC; CONVST pulse; wait T_CONV_CYC; 12 SCK with SDI=100010 -> SDO sequence 1010_1011_1100, conv_ch=0, frame_done once, cfg_word=100010.
- Frame 1 with SDI=111110, frame 2 with CH7=12'h123 -> frame 2 returns 12'h123, conv_ch=7.
- Config 111100 (UNI=0, CH7) on CH7=12'h000 -> next frame returns 12'h800; CH7=12'hFFF -> 12'h7FF.
- SCK pulses 10 clk after CONVST (before T_CONV_CYC) -> proto_err pulses, SDO stays 0, conversion still completes.
- CONVST after 4 SCK rising edges with SDI=1100.. -> proto_err, cfg_word stays 100010; repeat with abort after 7 edges -> cfg_word updated.
- Assert reset_n low mid-SHIFT -> SDO=0, cfg_word=100010 immediately; next frame returns CH0 data.
- Config with S/D=0 (e.g. 000010) -> next frame returns 12'h000; diff_seen=1 and stays 1 until reset.

Source files
------------

// File: rtl/ltc2308_emulator_if.sv
// ADC-side serial pins of the LTC2308: CONVST/SCK/SDI come from the master, SDO goes back.
interface ltc2308_emulator_if;
  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
  modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/ltc2308_emulator.sv
// Responder model of the LTC2308 8-channel 12-bit SPI ADC, oversampling the pins on clk.
module ltc2308_emulator #(
  parameter int unsigned        DATA_BITS   = 12,
  parameter int unsigned        CMD_BITS    = 6,
  parameter int unsigned        T_CONV_CYC  = 260,
  parameter logic [CMD_BITS-1:0] CFG_DEFAULT = 6'b100010
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*DATA_BITS-1:0] ch_data,
  ltc2308_emulator_if.slave      adc,
  output logic                   conv_start,
  output logic [2:0]             conv_ch,
  output logic [CMD_BITS-1:0]    cfg_word,
  output logic                   frame_done,
  output logic                   proto_err,
  output logic                   diff_seen
);

  localparam int unsigned CNT_W   = $clog2(T_CONV_CYC + 1);
  localparam int unsigned BCNT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned SD_BIT  = 5;
  localparam int unsigned OS_BIT  = 4;
  localparam int unsigned S1_BIT  = 3;
  localparam int unsigned S0_BIT  = 2;
  localparam int unsigned UNI_BIT = 1;

  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(T_CONV_CYC - 1);
  localparam logic [BCNT_W-1:0]    CMD_CNT   = BCNT_W'(CMD_BITS);
  localparam logic [BCNT_W-1:0]    LAST_BIT  = BCNT_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] SIGN_FLIP = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_SHIFT, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            convst_sync_q, sck_sync_q, sdi_sync_q;
  logic                  convst_dly_q, sck_dly_q;
  logic                  convst_rise_c, sck_rise_c, sck_fall_c, sdi_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  out_sr_q, out_sr_d;
  logic [DATA_BITS-1:0]  code_q, code_d;
  logic [CMD_BITS-1:0]   cfg_sr_q, cfg_sr_d;
  logic [CMD_BITS-1:0]   cfg_word_q, cfg_word_d;
  logic [CMD_BITS-1:0]   cfg_next_c;
  logic [2:0]            conv_ch_q, conv_ch_d, ch_sel_c;
  logic [DATA_BITS-1:0]  ch_arr [8];
  logic [DATA_BITS-1:0]  sample_c;
  logic                  trail_q, trail_d;
  logic                  sdo_q, sdo_d;
  logic                  conv_start_q, conv_start_d;
  logic                  frame_done_q, frame_done_d;
  logic                  proto_err_q, proto_err_d;
  logic                  diff_seen_q, diff_seen_d;
  logic                  start_c;

  // Two-FF synchronizers plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync_q <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      convst_dly_q  <= 1'b0;
      sck_dly_q     <= 1'b0;
    end else begin
      convst_sync_q <= {convst_sync_q[0], adc.ADC_CONVST};
      sck_sync_q    <= {sck_sync_q[0], adc.ADC_SCK};
      sdi_sync_q    <= {sdi_sync_q[0], adc.ADC_SDI};
      convst_dly_q  <= convst_sync_q[1];
      sck_dly_q     <= sck_sync_q[1];
    end
  end

  assign convst_rise_c = convst_sync_q[1] & ~convst_dly_q;
  assign sck_rise_c    = sck_sync_q[1] & ~sck_dly_q;
  assign sck_fall_c    = ~sck_sync_q[1] & sck_dly_q;
  assign sdi_c         = sdi_sync_q[1];

  // Unpack the parallel sample bus into per-channel words
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ch_arr[i] = ch_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Next-state, datapath and pulse decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    out_sr_d     = out_sr_q;
    code_d       = code_q;
    cfg_sr_d     = cfg_sr_q;
    cfg_word_d   = cfg_word_q;
    conv_ch_d    = conv_ch_q;
    trail_d      = trail_q;
    sdo_d        = sdo_q;
    diff_seen_d  = diff_seen_q;
    conv_start_d = 1'b0;
    frame_done_d = 1'b0;
    proto_err_d  = 1'b0;
    start_c      = 1'b0;
    cfg_next_c   = cfg_word_q;
    ch_sel_c     = 3'd0;
    sample_c     = '0;

    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (convst_rise_c) begin
          start_c = 1'b1;
        end
      end

      ST_CONV: begin
        if (convst_rise_c || sck_rise_c || sck_fall_c) begin
          proto_err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d   = ST_SHIFT;
          out_sr_d  = code_q;
          bit_cnt_d = '0;
          sdo_d     = code_q[DATA_BITS-1];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (convst_rise_c) begin
          // Aborted frame: keep the config only if all of it was clocked in
          proto_err_d = 1'b1;
          if (bit_cnt_q >= CMD_CNT) begin
            cfg_next_c = cfg_sr_q;
          end
          cfg_word_d = cfg_next_c;
          start_c    = 1'b1;
        end else begin
          if (sck_rise_c) begin
            if (bit_cnt_q < CMD_CNT) begin
              cfg_sr_d = {cfg_sr_q[CMD_BITS-2:0], sdi_c};
            end
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              frame_done_d = 1'b1;
              cfg_word_d   = cfg_sr_q;
              trail_d      = 1'b1;
              state_d      = ST_DONE;
            end
          end
          if (sck_fall_c) begin
            out_sr_d = {out_sr_q[DATA_BITS-2:0], 1'b0};
            sdo_d    = out_sr_q[DATA_BITS-2];
          end
        end
      end

      ST_DONE: begin
        if (convst_rise_c) begin
          start_c = 1'b1;
        end else if (sck_fall_c && trail_q) begin
          // Trailing falling edge of the frame shifts the last bit out
          out_sr_d = {out_sr_q[DATA_BITS-2:0], 1'b0};
          sdo_d    = out_sr_q[DATA_BITS-2];
          trail_d  = 1'b0;
        end else if (sck_rise_c || sck_fall_c) begin
          proto_err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Latch a new conversion using the config in force after any commit above
    if (start_c) begin
      ch_sel_c     = {cfg_next_c[S1_BIT], cfg_next_c[S0_BIT], cfg_next_c[OS_BIT]};
      sample_c     = ch_arr[ch_sel_c];
      state_d      = ST_CONV;
      cnt_d        = CNT_LOAD;
      bit_cnt_d    = '0;
      cfg_sr_d     = '0;
      trail_d      = 1'b0;
      sdo_d        = 1'b0;
      conv_start_d = 1'b1;
      conv_ch_d    = ch_sel_c;
      if (!cfg_next_c[SD_BIT]) begin
        code_d      = '0;
        diff_seen_d = 1'b1;
      end else if (cfg_next_c[UNI_BIT]) begin
        code_d = sample_c;
      end else begin
        code_d = sample_c ^ SIGN_FLIP;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      out_sr_q     <= '0;
      code_q       <= '0;
      cfg_sr_q     <= '0;
      cfg_word_q   <= CFG_DEFAULT;
      conv_ch_q    <= 3'd0;
      trail_q      <= 1'b0;
      sdo_q        <= 1'b0;
      diff_seen_q  <= 1'b0;
      conv_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      out_sr_q     <= out_sr_d;
      code_q       <= code_d;
      cfg_sr_q     <= cfg_sr_d;
      cfg_word_q   <= cfg_word_d;
      conv_ch_q    <= conv_ch_d;
      trail_q      <= trail_d;
      sdo_q        <= sdo_d;
      diff_seen_q  <= diff_seen_d;
      conv_start_q <= conv_start_d;
      frame_done_q <= frame_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign adc.ADC_SDO = sdo_q;
  assign conv_start  = conv_start_q;
  assign conv_ch     = conv_ch_q;
  assign cfg_word    = cfg_word_q;
  assign frame_done  = frame_done_q;
  assign proto_err   = proto_err_q;
  assign diff_seen   = diff_seen_q;

endmodule
